wb_arbiter: RTL and testbench

Writeback stage directly upstream of the register file's single write port (wadd/wdi/wen). It merges single-cycle ALU results with results from long-latency units (load path, multiply/divide), buffering the latter in a small FIFO. It also keeps a per-register pending scoreboard so decode stalls on operands whose long-latency write has not yet retired.

---
 rtl/wb_pkg.sv | 17 +
 rtl/wb_arbiter_if.sv | 35 +++
 rtl/wb_fifo.sv | 50 +++++
 rtl/wb_arbiter.sv | 89 ++++++++
 tb/tb_wb_arbiter.sv | 228 ++++++++++++++++++++++
 5 files changed

// File: rtl/wb_pkg.sv
// Shared widths, writeback entry layout and the occupancy-width helper
// for the writeback arbiter slice.
package wb_pkg;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int NREG   = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] REG_ZERO = 5'd0;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wb_entry_t;

  function automatic int cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction
endpackage

// File: rtl/wb_arbiter_if.sv
// Pipeline-side bundle of the writeback arbiter: ALU and long-latency results,
// issue/decode scoreboard taps and the register file write port.
interface wb_arbiter_if import wb_pkg::*; #(parameter int DEPTH = 4);
  localparam int CNT_W = cnt_w(DEPTH);

  logic              alu_wen;
  logic [ADDR_W-1:0] alu_wadd;
  logic [DATA_W-1:0] alu_wdi;
  logic              lng_valid;
  logic              lng_ready;
  logic [ADDR_W-1:0] lng_wadd;
  logic [DATA_W-1:0] lng_wdi;
  logic              iss_en;
  logic [ADDR_W-1:0] iss_wadd;
  logic [ADDR_W-1:0] chk_add1;
  logic [ADDR_W-1:0] chk_add2;
  logic              stall;
  logic              wen;
  logic [ADDR_W-1:0] wadd;
  logic [DATA_W-1:0] wdi;
  logic [CNT_W-1:0]  fifo_cnt;
  logic              hz_err;

  modport slave (
    input  alu_wen, alu_wadd, alu_wdi, lng_valid, lng_wadd, lng_wdi,
           iss_en, iss_wadd, chk_add1, chk_add2,
    output lng_ready, stall, wen, wadd, wdi, fifo_cnt, hz_err
  );

  modport master (
    output alu_wen, alu_wadd, alu_wdi, lng_valid, lng_wadd, lng_wdi,
           iss_en, iss_wadd, chk_add1, chk_add2,
    input  lng_ready, stall, wen, wadd, wdi, fifo_cnt, hz_err
  );
endinterface

// File: rtl/wb_fifo.sv
// DEPTH-entry synchronous FIFO of writeback entries; head is visible
// combinationally, pushes while full and pops while empty are ignored.
module wb_fifo import wb_pkg::*; #(
  parameter  int DEPTH = 4,
  localparam int CNT_W = cnt_w(DEPTH),
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             res,
  input  logic             push,
  input  wb_entry_t        push_dat,
  input  logic             pop,
  output wb_entry_t        head,
  output logic [CNT_W-1:0] cnt,
  output logic             full,
  output logic             empty
);
  wb_entry_t        mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (cnt == CNT_W'(DEPTH));
  assign empty   = (cnt == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign head    = mem[rd_ptr];

  // DEPTH is a power of two, so the pointers wrap by plain overflow.
  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_dat;
  end
endmodule

// File: rtl/wb_arbiter.sv
// Register file writeback merge: ALU results win, long-latency results drain
// from a FIFO in ALU bubbles; a pending scoreboard drives decode stall.
module wb_arbiter import wb_pkg::*; #(
  parameter int DEPTH = 4
) (
  input  logic     clk,
  input  logic     res,
  wb_arbiter_if.slave bus
);
  localparam int CNT_W = cnt_w(DEPTH);

  wb_entry_t         head;
  logic [CNT_W-1:0]  cnt;
  logic              full;
  logic              empty;
  logic              alu_act;
  logic              push;
  logic              pop;
  logic              hz_set;
  logic [NREG-1:0]   pending;
  logic [NREG-1:0]   pending_nxt;
  logic              wen_q;
  logic [ADDR_W-1:0] wadd_q;
  logic [DATA_W-1:0] wdi_q;
  logic              hz_q;

  assign alu_act = bus.alu_wen && (bus.alu_wadd != REG_ZERO);
  assign push    = bus.lng_valid && !full;
  assign pop     = !alu_act && !empty;

  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk      (clk),
    .res      (res),
    .push     (push),
    .push_dat ('{addr: bus.lng_wadd, data: bus.lng_wdi}),
    .pop      (pop),
    .head     (head),
    .cnt      (cnt),
    .full     (full),
    .empty    (empty)
  );

  // Issue is applied after retire so a same-edge set/clear leaves the bit set.
  always_comb begin
    pending_nxt = pending;
    if (pop)        pending_nxt[head.addr]    = 1'b0;
    if (bus.iss_en) pending_nxt[bus.iss_wadd] = 1'b1;
    pending_nxt[0] = 1'b0;
  end

  always_comb begin
    hz_set = 1'b0;
    if (alu_act && pending[bus.alu_wadd])                         hz_set = 1'b1;
    if (pop && (head.addr != REG_ZERO) && !pending[head.addr])    hz_set = 1'b1;
  end

  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      wen_q   <= 1'b0;
      wadd_q  <= '0;
      wdi_q   <= '0;
      pending <= '0;
      hz_q    <= 1'b0;
    end else begin
      pending <= pending_nxt;
      hz_q    <= hz_q | hz_set;
      if (alu_act) begin
        wen_q  <= 1'b1;
        wadd_q <= bus.alu_wadd;
        wdi_q  <= bus.alu_wdi;
      end else if (pop) begin
        wen_q  <= (head.addr != REG_ZERO);
        wadd_q <= head.addr;
        wdi_q  <= head.data;
      end else begin
        wen_q  <= 1'b0;
      end
    end
  end

  assign bus.lng_ready = !full;
  assign bus.fifo_cnt  = cnt;
  assign bus.wen       = wen_q;
  assign bus.wadd      = wadd_q;
  assign bus.wdi       = wdi_q;
  assign bus.hz_err    = hz_q;
  assign bus.stall     = pending[bus.chk_add1] | pending[bus.chk_add2] |
                         (bus.iss_en & pending[bus.iss_wadd]);
endmodule

// File: tb/tb_wb_arbiter.sv
// Directed scenario bench for wb_arbiter; expected values are hand-computed
// per scenario and compared inline.
module tb_wb_arbiter;
  logic clk = 1'b0;
  logic res = 1'b1;
  int   n_chk  = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  wb_arbiter_if #(.DEPTH(4)) bus ();

  wb_arbiter #(.DEPTH(4)) dut (
    .clk (clk),
    .res (res),
    .bus (bus.slave)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.alu_wen   = 1'b0;
    bus.alu_wadd  = '0;
    bus.alu_wdi   = '0;
    bus.lng_valid = 1'b0;
    bus.lng_wadd  = '0;
    bus.lng_wdi   = '0;
    bus.iss_en    = 1'b0;
    bus.iss_wadd  = '0;
    bus.chk_add1  = '0;
    bus.chk_add2  = '0;
  endtask

  task automatic do_reset();
    idle();
    res = 1'b1;
    step();
    res = 1'b0;
    step();
  endtask

  task automatic issue(input logic [4:0] r);
    bus.iss_en = 1'b1; bus.iss_wadd = r;
    step();
    bus.iss_en = 1'b0;
  endtask

  task automatic test_reset();
    idle();
    res = 1'b1;
    #2;
    n_chk++; if (bus.wen !== 1'b0) begin n_fail++; $display("FAIL rst_wen got %0b want 0", bus.wen); end
    n_chk++; if (bus.fifo_cnt !== 3'd0) begin n_fail++; $display("FAIL rst_cnt got %0d want 0", bus.fifo_cnt); end
    n_chk++; if (bus.hz_err !== 1'b0) begin n_fail++; $display("FAIL rst_hz got %0b want 0", bus.hz_err); end
    step();
    res = 1'b0;
    step();
    n_chk++; if (bus.lng_ready !== 1'b1) begin n_fail++; $display("FAIL rst_ready got %0b want 1", bus.lng_ready); end
    // Build state: r2 pending, two entries held behind ALU writes.
    issue(5'd2);
    bus.alu_wen = 1'b1; bus.alu_wadd = 5'd1; bus.alu_wdi = 32'h11;
    bus.lng_valid = 1'b1; bus.lng_wadd = 5'd2; bus.lng_wdi = 32'h22;
    step();
    bus.lng_wadd = 5'd3; bus.lng_wdi = 32'h33;
    step();
    idle();
    bus.chk_add1 = 5'd2;
    #1;
    n_chk++; if (bus.fifo_cnt !== 3'd2) begin n_fail++; $display("FAIL pre_rst_cnt got %0d want 2", bus.fifo_cnt); end
    n_chk++; if (bus.stall !== 1'b1) begin n_fail++; $display("FAIL pre_rst_stall got %0b want 1", bus.stall); end
    #2 res = 1'b1;
    #1;
    n_chk++; if (bus.wen !== 1'b0) begin n_fail++; $display("FAIL mid_rst_wen got %0b want 0", bus.wen); end
    n_chk++; if (bus.fifo_cnt !== 3'd0) begin n_fail++; $display("FAIL mid_rst_cnt got %0d want 0", bus.fifo_cnt); end
    n_chk++; if (bus.stall !== 1'b0) begin n_fail++; $display("FAIL mid_rst_stall got %0b want 0", bus.stall); end
    n_chk++; if (bus.hz_err !== 1'b0) begin n_fail++; $display("FAIL mid_rst_hz got %0b want 0", bus.hz_err); end
    #1 res = 1'b0;
    step();
    n_chk++; if (bus.lng_ready !== 1'b1) begin n_fail++; $display("FAIL post_rst_ready got %0b want 1", bus.lng_ready); end
    n_chk++; if (bus.wen !== 1'b0) begin n_fail++; $display("FAIL post_rst_wen got %0b want 0", bus.wen); end
  endtask

  task automatic test_alu();
    idle();
    bus.alu_wen = 1'b1; bus.alu_wadd = 5'd7; bus.alu_wdi = 32'hDEADBEEF;
    step();
    n_chk++; if (bus.wen !== 1'b1) begin n_fail++; $display("FAIL alu_wen got %0b want 1", bus.wen); end
    n_chk++; if (bus.wadd !== 5'd7) begin n_fail++; $display("FAIL alu_wadd got %0d want 7", bus.wadd); end
    n_chk++; if (bus.wdi !== 32'hDEADBEEF) begin n_fail++; $display("FAIL alu_wdi got %h want deadbeef", bus.wdi); end
    bus.alu_wadd = 5'd0; bus.alu_wdi = 32'h1;
    step();
    n_chk++; if (bus.wen !== 1'b0) begin n_fail++; $display("FAIL alu_r0_wen got %0b want 0", bus.wen); end
    idle();
    step();
  endtask

  task automatic test_long();
    idle();
    issue(5'd9);
    bus.chk_add1 = 5'd9;
    #1;
    n_chk++; if (bus.stall !== 1'b1) begin n_fail++; $display("FAIL lng_stall got %0b want 1", bus.stall); end
    bus.chk_add1 = 5'd0; bus.iss_en = 1'b1; bus.iss_wadd = 5'd9;
    #1;
    n_chk++; if (bus.stall !== 1'b1) begin n_fail++; $display("FAIL waw_stall got %0b want 1", bus.stall); end
    bus.iss_en = 1'b0; bus.chk_add2 = 5'd9;
    bus.lng_valid = 1'b1; bus.lng_wadd = 5'd9; bus.lng_wdi = 32'h1234;
    step();
    bus.lng_valid = 1'b0;
    n_chk++; if (bus.fifo_cnt !== 3'd1) begin n_fail++; $display("FAIL lng_cnt1 got %0d want 1", bus.fifo_cnt); end
    n_chk++; if (bus.wen !== 1'b0) begin n_fail++; $display("FAIL lng_early_wen got %0b want 0", bus.wen); end
    step();
    n_chk++; if (bus.wen !== 1'b1 || bus.wadd !== 5'd9 || bus.wdi !== 32'h1234) begin
      n_fail++; $display("FAIL lng_write got wen=%0b wadd=%0d wdi=%h want 1/9/1234", bus.wen, bus.wadd, bus.wdi); end
    n_chk++; if (bus.stall !== 1'b0) begin n_fail++; $display("FAIL lng_unstall got %0b want 0", bus.stall); end
    n_chk++; if (bus.fifo_cnt !== 3'd0) begin n_fail++; $display("FAIL lng_cnt0 got %0d want 0", bus.fifo_cnt); end
    idle();
    step();
  endtask

  task automatic test_contention();
    logic [4:0] exp_a [4];
    logic [2:0] exp_c [4];
    exp_a[0] = 5'd5; exp_a[1] = 5'd6; exp_a[2] = 5'd3; exp_a[3] = 5'd4;
    exp_c[0] = 3'd2; exp_c[1] = 3'd2; exp_c[2] = 3'd1; exp_c[3] = 3'd0;
    idle();
    issue(5'd3);
    issue(5'd4);
    bus.alu_wen = 1'b1; bus.alu_wadd = 5'd1; bus.alu_wdi = 32'h1;
    bus.lng_valid = 1'b1; bus.lng_wadd = 5'd3; bus.lng_wdi = 32'h33;
    step();
    bus.alu_wadd = 5'd2; bus.lng_wadd = 5'd4; bus.lng_wdi = 32'h44;
    step();
    bus.lng_valid = 1'b0;
    bus.alu_wadd = 5'd5; bus.alu_wdi = 32'h55;
    for (int i = 0; i < 4; i++) begin
      if (i == 1) begin bus.alu_wadd = 5'd6; bus.alu_wdi = 32'h66; end
      if (i == 2) bus.alu_wen = 1'b0;
      step();
      n_chk++; if (bus.wen !== 1'b1 || bus.wadd !== exp_a[i] || bus.fifo_cnt !== exp_c[i]) begin
        n_fail++; $display("FAIL cont_%0d got wen=%0b wadd=%0d cnt=%0d want 1/%0d/%0d",
                           i, bus.wen, bus.wadd, bus.fifo_cnt, exp_a[i], exp_c[i]); end
    end
    n_chk++; if (bus.hz_err !== 1'b0) begin n_fail++; $display("FAIL cont_hz got %0b want 0", bus.hz_err); end
    idle();
    step();
  endtask

  task automatic test_full();
    idle();
    for (int i = 0; i < 5; i++) issue(5'(10 + i));
    bus.alu_wen = 1'b1; bus.alu_wadd = 5'd1; bus.alu_wdi = 32'h1;
    for (int i = 0; i < 4; i++) begin
      bus.lng_valid = 1'b1; bus.lng_wadd = 5'(10 + i); bus.lng_wdi = 32'hA0 + i;
      step();
    end
    n_chk++; if (bus.fifo_cnt !== 3'd4) begin n_fail++; $display("FAIL full_cnt got %0d want 4", bus.fifo_cnt); end
    n_chk++; if (bus.lng_ready !== 1'b0) begin n_fail++; $display("FAIL full_ready got %0b want 0", bus.lng_ready); end
    bus.lng_wadd = 5'd14; bus.lng_wdi = 32'hA4;
    step();
    n_chk++; if (bus.fifo_cnt !== 3'd4) begin n_fail++; $display("FAIL full_hold_cnt got %0d want 4", bus.fifo_cnt); end
    bus.alu_wen = 1'b0;
    step();
    n_chk++; if (bus.fifo_cnt !== 3'd3 || bus.wadd !== 5'd10) begin
      n_fail++; $display("FAIL full_pop_nopush got cnt=%0d wadd=%0d want 3/10", bus.fifo_cnt, bus.wadd); end
    n_chk++; if (bus.lng_ready !== 1'b1) begin n_fail++; $display("FAIL full_ready2 got %0b want 1", bus.lng_ready); end
    step();
    bus.lng_valid = 1'b0;
    n_chk++; if (bus.fifo_cnt !== 3'd3 || bus.wadd !== 5'd11) begin
      n_fail++; $display("FAIL full_pushpop got cnt=%0d wadd=%0d want 3/11", bus.fifo_cnt, bus.wadd); end
    for (int i = 0; i < 3; i++) begin
      step();
      n_chk++; if (bus.wen !== 1'b1 || bus.wadd !== 5'(12 + i) || bus.wdi !== 32'hA2 + i) begin
        n_fail++; $display("FAIL drain_%0d got wen=%0b wadd=%0d wdi=%h want 1/%0d/%h",
                           i, bus.wen, bus.wadd, bus.wdi, 12 + i, 32'hA2 + i); end
    end
    n_chk++; if (bus.fifo_cnt !== 3'd0 || bus.hz_err !== 1'b0) begin
      n_fail++; $display("FAIL drain_end got cnt=%0d hz=%0b want 0/0", bus.fifo_cnt, bus.hz_err); end
    idle();
    step();
  endtask

  task automatic test_errors();
    idle();
    issue(5'd9);
    bus.lng_valid = 1'b1; bus.lng_wadd = 5'd9; bus.lng_wdi = 32'h99;
    step();
    bus.lng_valid = 1'b0;
    bus.iss_en = 1'b1; bus.iss_wadd = 5'd9;
    step();
    bus.iss_en = 1'b0; bus.chk_add1 = 5'd9;
    #1;
    n_chk++; if (bus.stall !== 1'b1) begin n_fail++; $display("FAIL collide_pending got %0b want 1", bus.stall); end
    n_chk++; if (bus.wen !== 1'b1 || bus.wadd !== 5'd9 || bus.hz_err !== 1'b0) begin
      n_fail++; $display("FAIL collide_pop got wen=%0b wadd=%0d hz=%0b want 1/9/0", bus.wen, bus.wadd, bus.hz_err); end
    bus.alu_wen = 1'b1; bus.alu_wadd = 5'd9; bus.alu_wdi = 32'h5;
    step();
    bus.alu_wen = 1'b0;
    n_chk++; if (bus.hz_err !== 1'b1) begin n_fail++; $display("FAIL alu_hz got %0b want 1", bus.hz_err); end
    step();
    step();
    n_chk++; if (bus.hz_err !== 1'b1) begin n_fail++; $display("FAIL hz_sticky got %0b want 1", bus.hz_err); end
    do_reset();
    n_chk++; if (bus.hz_err !== 1'b0) begin n_fail++; $display("FAIL hz_clear got %0b want 0", bus.hz_err); end
    bus.lng_valid = 1'b1; bus.lng_wadd = 5'd12; bus.lng_wdi = 32'hC;
    step();
    bus.lng_valid = 1'b0;
    n_chk++; if (bus.hz_err !== 1'b0) begin n_fail++; $display("FAIL pop12_early got %0b want 0", bus.hz_err); end
    step();
    n_chk++; if (bus.hz_err !== 1'b1) begin n_fail++; $display("FAIL pop12_hz got %0b want 1", bus.hz_err); end
    idle();
    step();
  endtask

  initial begin
    test_reset();
    test_alu();
    test_long();
    test_contention();
    test_full();
    test_errors();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
